imem_boot_ctrl: RTL and testbench

- Boot and test sequencer for the RVSEED core inside HISOC.
- Holds the core in reset and accepts a program as a valid/ready word stream. Writes the words into the instruction memory from address 0, then releases the core.
- Monitors the core for a halt indication or a timeout and reports pass/fail.
- Replaces host-side memory preloading, so back-to-back instruction tests can run on silicon and in simulation.

---
 rtl/imem_boot_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_imem_boot_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_ctrl.sv
// Boot/test sequencer for the RVSEED core: streams a program into instruction
// memory, releases the core, then watches for halt or timeout and reports.
module imem_boot_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int RST_CYC = 2,
  parameter int RUN_MAX = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst_n,
  input  logic              halt,
  input  logic [DATA_W-1:0] halt_code,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              overflow,
  output logic [ADDR_W:0]   word_cnt,
  output logic [19:0]       cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RST_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] TOP_ADDR  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [7:0]      HOLD_LAST = 8'(RST_CYC - 1);
  // RUN_MAX = 2^20 truncates to 0; the run counter starts at 1, so it only
  // reads 0 after wrapping on exactly the 2^20-th run cycle.
  localparam logic [19:0]     RUN_LIMIT = 20'(RUN_MAX);

  state_t              state, state_nxt;
  logic [7:0]          hold_cnt, hold_cnt_nxt;
  logic                ld_ready_nxt, imem_we_nxt, core_rst_n_nxt;
  logic [ADDR_W-1:0]   imem_addr_nxt;
  logic [DATA_W-1:0]   imem_wdata_nxt;
  logic                busy_nxt, done_nxt, pass_nxt, timeout_nxt, overflow_nxt;
  logic [ADDR_W:0]     word_cnt_nxt;
  logic [19:0]         cycle_cnt_nxt;

  logic hs, load_end, halt_seen, run_expired;

  assign hs          = (state == S_LOAD) && ld_ready && ld_valid;
  assign load_end    = hs && (ld_last || (word_cnt == TOP_ADDR));
  assign halt_seen   = (state == S_RUN) && core_rst_n && halt;
  assign run_expired = (state == S_RUN) && (cycle_cnt == RUN_LIMIT);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous -- rst_n only takes effect on a rising clk edge.
    if (!rst_n) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      ld_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      overflow   <= 1'b0;
      word_cnt   <= '0;
      cycle_cnt  <= '0;
    end else begin
      // NOTE: non-blocking (<=) so every register samples pre-edge values.
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      ld_ready   <= ld_ready_nxt;
      imem_we    <= imem_we_nxt;
      imem_addr  <= imem_addr_nxt;
      imem_wdata <= imem_wdata_nxt;
      core_rst_n <= core_rst_n_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
      overflow   <= overflow_nxt;
      word_cnt   <= word_cnt_nxt;
      cycle_cnt  <= cycle_cnt_nxt;
    end
  end

  // Next state.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start)                         state_nxt = S_LOAD;
        S_LOAD:         if (load_end)                      state_nxt = S_RST_HOLD;
        S_RST_HOLD:     if (hold_cnt == HOLD_LAST)         state_nxt = S_RUN;
        S_RUN:          if (halt_seen || run_expired)      state_nxt = S_DONE;
        default:                                           state_nxt = S_IDLE;
      endcase
    end
  end

  // Next output values.
  always_comb begin
    // NOTE: every target gets a default first so no path infers a latch.
    hold_cnt_nxt   = hold_cnt;
    ld_ready_nxt   = ld_ready;
    imem_we_nxt    = 1'b0;
    imem_addr_nxt  = imem_addr;
    imem_wdata_nxt = imem_wdata;
    core_rst_n_nxt = core_rst_n;
    busy_nxt       = busy;
    done_nxt       = done;
    pass_nxt       = pass;
    timeout_nxt    = timeout;
    overflow_nxt   = overflow;
    word_cnt_nxt   = word_cnt;
    cycle_cnt_nxt  = cycle_cnt;

    if (abort) begin
      ld_ready_nxt   = 1'b0;
      core_rst_n_nxt = 1'b0;
      busy_nxt       = 1'b0;
      done_nxt       = 1'b0;
      pass_nxt       = 1'b0;
      timeout_nxt    = 1'b0;
      overflow_nxt   = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            ld_ready_nxt   = 1'b1;
            core_rst_n_nxt = 1'b0;
            busy_nxt       = 1'b1;
            done_nxt       = 1'b0;
            pass_nxt       = 1'b0;
            timeout_nxt    = 1'b0;
            overflow_nxt   = 1'b0;
            word_cnt_nxt   = '0;
            cycle_cnt_nxt  = '0;
          end
        end
        S_LOAD: begin
          if (hs) begin
            imem_we_nxt    = 1'b1;
            imem_addr_nxt  = word_cnt[ADDR_W-1:0];
            imem_wdata_nxt = ld_data;
            word_cnt_nxt   = word_cnt + 1'b1;
          end
          if (load_end) begin
            ld_ready_nxt = 1'b0;
            hold_cnt_nxt = '0;
            overflow_nxt = !ld_last;
          end
        end
        S_RST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            core_rst_n_nxt = 1'b1;
            cycle_cnt_nxt  = 20'd1;
          end else begin
            hold_cnt_nxt = hold_cnt + 8'd1;
          end
        end
        S_RUN: begin
          if (halt_seen || run_expired) begin
            // Halt wins over a timeout landing in the same cycle.
            done_nxt       = 1'b1;
            pass_nxt       = halt_seen && (halt_code == '0);
            timeout_nxt    = !halt_seen;
            busy_nxt       = 1'b0;
            core_rst_n_nxt = 1'b0;
          end else begin
            cycle_cnt_nxt = cycle_cnt + 20'd1;
          end
        end
        default: begin
          ld_ready_nxt   = 1'b0;
          core_rst_n_nxt = 1'b0;
          busy_nxt       = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed bench for imem_boot_ctrl: default instance plus an ADDR_W=3 /
// RUN_MAX=20 instance for the overflow path.
module tb_imem_boot_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, ld_valid, ld_last, halt;
  logic [31:0] ld_data, halt_code;
  logic        ld_ready, imem_we, core_rst_n, busy, done, pass, timeout, overflow;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_cnt;
  logic [19:0] cycle_cnt;

  logic        start_b, abort_b, ld_valid_b, ld_last_b, halt_b;
  logic [31:0] ld_data_b, halt_code_b;
  logic        ld_ready_b, imem_we_b, core_rst_n_b, busy_b, done_b, pass_b, timeout_b, overflow_b;
  logic [2:0]  imem_addr_b;
  logic [31:0] imem_wdata_b;
  logic [3:0]  word_cnt_b;
  logic [19:0] cycle_cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  imem_boot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n), .halt(halt), .halt_code(halt_code),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .overflow(overflow),
    .word_cnt(word_cnt), .cycle_cnt(cycle_cnt)
  );

  imem_boot_ctrl #(.ADDR_W(3), .DATA_W(32), .RST_CYC(2), .RUN_MAX(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .ld_valid(ld_valid_b), .ld_ready(ld_ready_b), .ld_data(ld_data_b), .ld_last(ld_last_b),
    .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
    .core_rst_n(core_rst_n_b), .halt(halt_b), .halt_code(halt_code_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(timeout_b), .overflow(overflow_b),
    .word_cnt(word_cnt_b), .cycle_cnt(cycle_cnt_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", ld_ready, 1);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input int addr);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("wr_we", imem_we, 1);
    check("wr_addr", imem_addr, addr);
    check("wr_data", imem_wdata, d);
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (core_rst_n !== 1'b1 && n < budget) begin tick(); n++; end
    check("wait_run", core_rst_n, 1);
  endtask

  task automatic wait_cycle(input int target, input int budget);
    int n = 0;
    while (cycle_cnt !== 20'(target) && n < budget) begin tick(); n++; end
    check("wait_cycle", cycle_cnt, target);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin tick(); n++; end
    check("wait_done", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] prog [4];
    int n;
    prog[0] = 32'h0000_0013;
    prog[1] = 32'h0010_0093;
    prog[2] = 32'h0020_0113;
    prog[3] = 32'h0000_0073;

    // Reset with inputs toggling.
    rst_n = 1'b0;
    ld_data = 32'hDEAD_BEEF; halt_code = '0; ld_last = 1'b0;
    ld_data_b = '0; halt_code_b = '0; ld_last_b = 1'b0; halt_b = 1'b0; abort_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'(i); abort = 1'(i >> 1); ld_valid = 1'b1; halt = 1'(~i);
      start_b = 1'(i); ld_valid_b = 1'b1;
      tick();
      check("rst_ctl", {ld_ready, imem_we, core_rst_n, busy, done, pass, timeout, overflow}, 0);
      check("rst_dat", {imem_addr, imem_wdata}, 0);
      check("rst_cnt", {word_cnt, cycle_cnt}, 0);
      check("rst_ctl_b", {ld_ready_b, imem_we_b, core_rst_n_b, busy_b, done_b, overflow_b}, 0);
    end
    start = 1'b0; abort = 1'b0; ld_valid = 1'b0; halt = 1'b0;
    start_b = 1'b0; ld_valid_b = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_ready", ld_ready, 0);
    check("idle_core", core_rst_n, 0);

    // 4-word program, ld_valid every other cycle, pass after 37 run cycles.
    do_start();
    for (int i = 0; i < 4; i++) begin
      send_word(prog[i], (i == 3), i);
      check("wc", word_cnt, i + 1);
      if (i < 3) begin
        tick();
        check("gap_we", imem_we, 0);
        check("gap_ready", ld_ready, 1);
      end
    end
    check("hold1_ready", ld_ready, 0);
    check("hold1_core", core_rst_n, 0);
    tick();
    check("hold2_core", core_rst_n, 0);
    check("hold2_we", imem_we, 0);
    tick();
    check("run1_core", core_rst_n, 1);
    check("run1_cyc", cycle_cnt, 1);
    repeat (36) tick();
    check("run37_cyc", cycle_cnt, 37);
    halt = 1'b1; halt_code = 32'd0;
    tick();
    halt = 1'b0;
    check("p_done", done, 1);
    check("p_pass", pass, 1);
    check("p_tmo", timeout, 0);
    check("p_busy", busy, 0);
    check("p_core", core_rst_n, 0);
    check("p_cyc", cycle_cnt, 37);
    check("p_wc", word_cnt, 4);
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    check("done_ign_we", imem_we, 0);
    check("done_ign_ready", ld_ready, 0);
    check("done_held", done, 1);
    check("cyc_held", cycle_cnt, 37);

    // One word, no halt: timeout at RUN_MAX.
    do_start();
    check("restart_done", done, 0);
    check("restart_wc", word_cnt, 0);
    send_word(32'h0000_006F, 1'b1, 0);
    wait_done(700);
    check("t_tmo", timeout, 1);
    check("t_pass", pass, 0);
    check("t_cyc", cycle_cnt, 500);
    check("t_core", core_rst_n, 0);
    check("t_busy", busy, 0);

    // Halt with nonzero code on the same cycle as the timeout.
    do_start();
    check("restart_tmo", timeout, 0);
    send_word(32'h0000_0073, 1'b1, 0);
    wait_cycle(500, 700);
    halt = 1'b1; halt_code = 32'd5;
    tick();
    halt = 1'b0; halt_code = '0;
    check("h_done", done, 1);
    check("h_pass", pass, 0);
    check("h_tmo", timeout, 0);
    check("h_cyc", cycle_cnt, 500);

    // Abort on word 2 of a load, together with start.
    do_start();
    send_word(prog[0], 1'b0, 0);
    send_word(prog[1], 1'b0, 1);
    ld_valid = 1'b1; ld_data = prog[2]; abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    check("al_we", imem_we, 0);
    check("al_busy", busy, 0);
    check("al_ready", ld_ready, 0);
    check("al_core", core_rst_n, 0);
    check("al_done", done, 0);
    tick();
    ld_valid = 1'b0;
    check("al_idle_we", imem_we, 0);
    check("al_idle_busy", busy, 0);
    do_start();
    send_word(prog[3], 1'b1, 0);
    check("al_reload_wc", word_cnt, 1);

    // Abort during RUN, together with start and halt.
    wait_run(10);
    repeat (3) tick();
    abort = 1'b1; start = 1'b1; halt = 1'b1; halt_code = '0;
    tick();
    abort = 1'b0; start = 1'b0; halt = 1'b0;
    check("ar_busy", busy, 0);
    check("ar_core", core_rst_n, 0);
    check("ar_done", done, 0);
    check("ar_pass", pass, 0);
    check("ar_we", imem_we, 0);
    tick();
    check("ar_idle_core", core_rst_n, 0);
    check("ar_idle_busy", busy, 0);
    do_start();
    send_word(32'h1234_5678, 1'b1, 0);

    // ADDR_W=3: ten words with no ld_last overflow the 8-word memory.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_ready", ld_ready_b, 1);
    for (int k = 0; k < 10; k++) begin
      ld_valid_b = 1'b1;
      ld_data_b  = 32'hA0 + 32'(k);
      tick();
      if (k < 8) begin
        check("b_we", imem_we_b, 1);
        check("b_addr", imem_addr_b, k);
        check("b_data", imem_wdata_b, 32'hA0 + 32'(k));
      end else begin
        check("b_stall_we", imem_we_b, 0);
        check("b_stall_ready", ld_ready_b, 0);
      end
      if (k == 7) begin
        check("b_ovf", overflow_b, 1);
        check("b_ready_drop", ld_ready_b, 0);
      end
    end
    ld_valid_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 100) begin tick(); n++; end
    check("b_done", done_b, 1);
    check("b_tmo", timeout_b, 1);
    check("b_ovf_held", overflow_b, 1);
    check("b_wc", word_cnt_b, 8);
    check("b_cyc", cycle_cnt_b, 20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
